control_unit_mc: RTL and testbench

- Multi-cycle control FSM sitting directly upstream of the 16x16 register file; R15 is the PC.
- Fetches a 16-bit instruction from memory, latches it in an internal IR, and decodes it.
- Drives the register file's read/write selects, RegWrite and incr_pc, plus ALU, write-back and memory controls.
- Sequences each instruction through FETCH and EXEC states with a memory ready handshake.

---
 rtl/control_unit_mc.sv | 173 +++++++++++++++++
 tb/tb_control_unit_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM in front of the 16x16 register file (R15 = PC).
// Fetches an instruction into IR, then sequences its execution, driving
// register-file selects, ALU/write-back selection and memory handshakes.
//
// state  | meaning
// IDLE   | waiting for run, all controls quiet
// FETCH  | reading instruction at PC, waiting for mem_ready
// EXEC   | executing IR; LD/ST wait here for mem_ready
// HALT   | HALT executed, only reset leaves this state
module control_unit_mc #(
  parameter int         DATA_W = 16,
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              alu_zero,
  output logic [3:0]        Read1,
  output logic [3:0]        Read2,
  output logic [3:0]        WriteReg,
  output logic              RegWrite,
  output logic              incr_pc,
  output logic [2:0]        alu_op,
  output logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] Imm,
  output logic              addr_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic              done,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] ir;
  logic              z_flag;
  logic              ir_load;
  logic              z_load;
  logic              retire;

  logic [3:0] op;
  logic [3:0] rx;
  logic [3:0] ry;

  assign op = ir[15:12];
  assign rx = ir[11:8];
  assign ry = ir[7:4];

  // State register; reset forces IDLE so every output drops without a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Instruction register, loaded on the completing FETCH cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ir <= '0;
    else if (ir_load) ir <= instr;
  end

  // Zero flag, updated only by the ALU ops; MVNZ consumes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       z_flag <= 1'b0;
    else if (z_load) z_flag <= alu_zero;
  end

  // Next-state and control decode; mem_ready-dependent terms are Mealy.
  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    z_load     = 1'b0;
    retire     = 1'b0;
    Read1      = 4'd0;
    Read2      = 4'd0;
    WriteReg   = 4'd0;
    RegWrite   = 1'b0;
    incr_pc    = 1'b0;
    alu_op     = 3'd0;
    wb_sel     = 2'd0;
    Imm        = '0;
    addr_sel   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    halted     = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) next_state = S_FETCH;
      end

      S_FETCH: begin
        Read1    = PC_REG;
        mem_read = 1'b1;
        if (mem_ready) begin
          incr_pc    = 1'b1;
          ir_load    = 1'b1;
          next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        Read1    = rx;
        Read2    = ry;
        WriteReg = rx;
        Imm      = {{(DATA_W-8){1'b0}}, ir[7:0]};
        case (op)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
            alu_op   = op[2:0];
            RegWrite = 1'b1;
            z_load   = 1'b1;
            retire   = 1'b1;
          end
          4'd5: begin
            wb_sel   = 2'd1;
            RegWrite = 1'b1;
            retire   = 1'b1;
          end
          4'd6: begin
            wb_sel   = 2'd2;
            RegWrite = 1'b1;
            retire   = 1'b1;
          end
          4'd7: begin
            addr_sel = 1'b1;
            mem_read = 1'b1;
            wb_sel   = 2'd3;
            RegWrite = mem_ready;
            retire   = mem_ready;
          end
          4'd8: begin
            addr_sel  = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
          end
          4'd9: begin
            wb_sel   = 2'd1;
            RegWrite = ~z_flag;
            retire   = 1'b1;
          end
          4'd15: begin
            next_state = S_HALT;
          end
          default: begin
            retire = 1'b1;
          end
        endcase
        if (retire) begin
          done       = 1'b1;
          next_state = run ? S_FETCH : S_IDLE;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: the stimulus pushes the hand-computed
// expected output vector for each cycle; a monitor pops and compares it on
// the falling edge of that cycle.
module tb_control_unit_mc;

  typedef struct packed {
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  wr;
    logic        rw;
    logic        inc;
    logic [2:0]  op;
    logic [1:0]  wb;
    logic [15:0] imm;
    logic        as;
    logic        mr;
    logic        mw;
    logic        dn;
    logic        hl;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic [3:0]  Read1;
  logic [3:0]  Read2;
  logic [3:0]  WriteReg;
  logic        RegWrite;
  logic        incr_pc;
  logic [2:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [15:0] Imm;
  logic        addr_sel;
  logic        mem_read;
  logic        mem_write;
  logic        done;
  logic        halted;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  control_unit_mc #(.DATA_W(16), .PC_REG(4'd15)) dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr),
    .mem_ready(mem_ready), .alu_zero(alu_zero),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .incr_pc(incr_pc), .alu_op(alu_op), .wb_sel(wb_sel), .Imm(Imm),
    .addr_sel(addr_sel), .mem_read(mem_read), .mem_write(mem_write),
    .done(done), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(logic [3:0] r1, logic [3:0] r2, logic [3:0] wr,
                              logic rw, logic inc, logic [2:0] op, logic [1:0] wb,
                              logic [15:0] imm, logic as, logic mr, logic mw,
                              logic dn, logic hl);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.wr = wr; e.rw = rw; e.inc = inc; e.op = op;
    e.wb = wb; e.imm = imm; e.as = as; e.mr = mr; e.mw = mw; e.dn = dn; e.hl = hl;
    return e;
  endfunction

  function automatic exp_t ez();
    return mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t ef(logic rdy);
    return mk(4'd15, 4'd0, 4'd0, 1'b0, rdy, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // Drive one cycle's inputs, queue its expectation (empty name = unchecked),
  // then advance to just after the next rising edge.
  task automatic cyc(input logic r, input logic [15:0] ins, input logic rdy,
                     input logic az, input exp_t e, input string nm);
    run       = r;
    instr     = ins;
    mem_ready = rdy;
    alu_zero  = az;
    if (nm != "") begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare the whole output vector against the queued expectation.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.r1 = Read1;   a.r2 = Read2;   a.wr = WriteReg; a.rw = RegWrite;
        a.inc = incr_pc; a.op = alu_op; a.wb = wb_sel;   a.imm = Imm;
        a.as = addr_sel; a.mr = mem_read; a.mw = mem_write; a.dn = done;
        a.hl = halted;
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got r1=%h r2=%h wr=%h rw=%b inc=%b op=%0d wb=%0d imm=%h as=%b mr=%b mw=%b done=%b halt=%b, expected r1=%h r2=%h wr=%h rw=%b inc=%b op=%0d wb=%0d imm=%h as=%b mr=%b mw=%b done=%b halt=%b",
                   nm, a.r1, a.r2, a.wr, a.rw, a.inc, a.op, a.wb, a.imm, a.as, a.mr, a.mw, a.dn, a.hl,
                   e.r1, e.r2, e.wr, e.rw, e.inc, e.op, e.wb, e.imm, e.as, e.mr, e.mw, e.dn, e.hl);
        end
      end
    end
  end

  initial begin
    exp_t ld_w, ld_r, st_w, st_r, hlt;
    ld_w = mk(4'd5, 4'd6, 4'd5, 1'b0, 1'b0, 3'd0, 2'd3, 16'h0060, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ld_r = mk(4'd5, 4'd6, 4'd5, 1'b1, 1'b0, 3'd0, 2'd3, 16'h0060, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    st_w = mk(4'd7, 4'd8, 4'd7, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0080, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    st_r = mk(4'd7, 4'd8, 4'd7, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0080, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    hlt  = mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    reset = 1'b1; run = 1'b0; instr = 16'h0000; mem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ez(), "reset_state");
    reset = 1'b0;

    // MVI R1,5
    cyc(1'b1, 16'h6105, 1'b1, 1'b0, ez(),      "idle_run");
    cyc(1'b1, 16'h6105, 1'b1, 1'b0, ef(1'b1),  "fetch_mvi");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0,
        mk(4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 3'd0, 2'd2, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_mvi");

    // ADD with zero result, then MVNZ not taken
    cyc(1'b1, 16'h0120, 1'b1, 1'b1, ef(1'b1),  "fetch_add_z1");
    cyc(1'b1, 16'h0000, 1'b1, 1'b1,
        mk(4'd1, 4'd2, 4'd1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_add_z1");
    cyc(1'b1, 16'h9340, 1'b1, 1'b0, ef(1'b1),  "fetch_mvnz_nt");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0,
        mk(4'd3, 4'd4, 4'd3, 1'b0, 1'b0, 3'd0, 2'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_mvnz_not_taken");

    // ADD with nonzero result, then MVNZ taken
    cyc(1'b1, 16'h0120, 1'b1, 1'b0, ef(1'b1),  "fetch_add_z0");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0,
        mk(4'd1, 4'd2, 4'd1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_add_z0");
    cyc(1'b1, 16'h9340, 1'b1, 1'b1, ef(1'b1),  "fetch_mvnz_t");
    cyc(1'b1, 16'h0000, 1'b1, 1'b1,
        mk(4'd3, 4'd4, 4'd3, 1'b1, 1'b0, 3'd0, 2'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_mvnz_taken");

    // SLT RA,RB
    cyc(1'b1, 16'h4AB0, 1'b1, 1'b0, ef(1'b1),  "fetch_slt");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0,
        mk(4'hA, 4'hB, 4'hA, 1'b1, 1'b0, 3'd4, 2'd0, 16'h00B0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_slt");

    // LD R5,[R6] with 3 wait cycles
    cyc(1'b1, 16'h7560, 1'b1, 1'b0, ef(1'b1),  "fetch_ld");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, ld_w,      "ld_wait1");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, ld_w,      "ld_wait2");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, ld_w,      "ld_wait3");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ld_r,      "ld_ready");

    // ST with 2 wait cycles
    cyc(1'b1, 16'h8780, 1'b1, 1'b0, ef(1'b1),  "fetch_st");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, st_w,      "st_wait1");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, st_w,      "st_wait2");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, st_r,      "st_ready");

    // FETCH stalled 4 cycles: incr_pc only on the ready cycle; then NOP
    cyc(1'b1, 16'hA123, 1'b0, 1'b0, ef(1'b0),  "fetch_stall1");
    cyc(1'b1, 16'hA123, 1'b0, 1'b0, ef(1'b0),  "fetch_stall2");
    cyc(1'b1, 16'hA123, 1'b0, 1'b0, ef(1'b0),  "fetch_stall3");
    cyc(1'b1, 16'hA123, 1'b0, 1'b0, ef(1'b0),  "fetch_stall4");
    cyc(1'b1, 16'hA123, 1'b1, 1'b0, ef(1'b1),  "fetch_stall_done");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0,
        mk(4'd1, 4'd2, 4'd1, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "exec_nop");

    // run dropped during LD wait: completes, then IDLE
    cyc(1'b1, 16'h7560, 1'b1, 1'b0, ef(1'b1),  "fetch_ld2");
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, ld_w,      "ld2_wait_run0");
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, ld_w,      "ld2_wait_run0b");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, ld_r,      "ld2_ready_run0");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, ez(),      "idle_after_ld2");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ez(),      "idle_rerun");

    // Reset asserted mid-LD: outputs drop before any clock edge
    cyc(1'b1, 16'h7560, 1'b1, 1'b0, ef(1'b1),  "fetch_ld3");
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, ld_w,      "ld3_wait");
    reset = 1'b1;
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ez(),      "reset_mid_ld");
    reset = 1'b0;

    // HALT: sticky, run toggling ignored, cleared only by reset
    cyc(1'b1, 16'hF000, 1'b1, 1'b0, ez(),      "idle_before_halt");
    cyc(1'b1, 16'hF000, 1'b1, 1'b0, ef(1'b1),  "fetch_halt");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ez(),      "");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, hlt,       "halt_run0");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, hlt,       "halt_run1");
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, hlt,       "halt_run0b");
    reset = 1'b1;
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, ez(),      "halt_reset");
    reset = 1'b0;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, ez(),      "idle_after_halt");

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
